// File: rtl/inst_fetch.sv
// Instruction fetch unit: PC/IR/IRPC pipeline register with IDLE/RUN/HALT control,
// PC-relative branches and halt. Optional retired-instruction counter under INST_FETCH_ICOUNT_EN.
module inst_fetch #(
  parameter logic [7:0] RESET_PC = 8'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [7:0]  start_addr_i,
  input  logic        stall_i,
  output logic [7:0]  address_o,
  input  logic [7:0]  inst_i,
  input  logic        br_cond_i,
  input  logic [7:0]  br_val_i,
  output logic [7:0]  inst_o,
  output logic        inst_valid_o,
  output logic        halted_o
`ifdef INST_FETCH_ICOUNT_EN
  ,
  output logic [15:0] icount_o
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;

  localparam logic [7:0] HALT_OP = 8'b1000_1000;

  state_t     state_reg, state_next;
  logic [7:0] pc_reg, pc_next;
  logic [7:0] ir_reg, ir_next;
  logic [7:0] irpc_reg, irpc_next;
  logic       valid_reg, valid_next;

  logic       is_fwd, is_bwd, taken, is_halt;
  logic [7:0] seq_pc, target;

  // Decode only acts on a live IR; a flushed or stale IR never redirects.
  always_comb begin
    is_fwd  = valid_reg && (ir_reg[7:3] == 5'b11110);
    is_bwd  = valid_reg && (ir_reg[7:3] == 5'b10110);
    taken   = (is_fwd || is_bwd) && br_cond_i;
    is_halt = valid_reg && (ir_reg == HALT_OP);
    seq_pc  = irpc_reg + 8'd1;
    target  = is_fwd ? (seq_pc + br_val_i) : (seq_pc - br_val_i);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      pc_reg    <= RESET_PC;
      ir_reg    <= 8'h00;
      irpc_reg  <= 8'h00;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      ir_reg    <= ir_next;
      irpc_reg  <= irpc_next;
      valid_reg <= valid_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    ir_next    = ir_reg;
    irpc_next  = irpc_reg;
    valid_next = valid_reg;
    case (state_reg)
      IDLE, HALT: begin
        if (start_i) begin
          state_next = RUN;
          pc_next    = start_addr_i;
          valid_next = 1'b0;
        end
      end
      RUN: begin
        // Restart outranks stall, branch and halt.
        if (start_i) begin
          pc_next    = start_addr_i;
          valid_next = 1'b0;
        end else if (!stall_i) begin
          if (taken) begin
            pc_next    = target;
            valid_next = 1'b0;
          end else if (is_halt) begin
            state_next = HALT;
            pc_next    = seq_pc;
            valid_next = 1'b0;
          end else begin
            ir_next    = inst_i;
            irpc_next  = pc_reg;
            pc_next    = pc_reg + 8'd1;
            valid_next = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        valid_next = 1'b0;
      end
    endcase
  end

  always_comb begin
    address_o    = pc_reg;
    inst_o       = ir_reg;
    inst_valid_o = valid_reg;
    halted_o     = (state_reg == HALT);
  end

`ifdef INST_FETCH_ICOUNT_EN
  logic [15:0] icount_reg;

  always_ff @(posedge clk) begin
    if (reset || start_i) begin
      icount_reg <= 16'h0000;
    end else if (valid_reg && !stall_i && (icount_reg != 16'hffff)) begin
      icount_reg <= icount_reg + 16'd1;
    end
  end

  assign icount_o = icount_reg;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic [7:0]  start_addr_i;
  logic        stall_i;
  logic [7:0]  address_o;
  logic [7:0]  inst_i;
  logic        br_cond_i;
  logic [7:0]  br_val_i;
  logic [7:0]  inst_o;
  logic        inst_valid_o;
  logic        halted_o;
`ifdef INST_FETCH_ICOUNT_EN
  logic [15:0] icount_o;
`endif

  logic [7:0] rom [256];

  typedef struct {
    logic [7:0] a;
    logic [7:0] i;
    logic       v;
    logic       h;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  logic [15:0] model_cnt = 16'h0000;
  logic        prev_valid = 1'b0;

  always #5 clk = ~clk;

  assign inst_i = rom[address_o];

  inst_fetch #(.RESET_PC(8'd0)) dut (
    .clk          (clk),
    .reset        (reset),
    .start_i      (start_i),
    .start_addr_i (start_addr_i),
    .stall_i      (stall_i),
    .address_o    (address_o),
    .inst_i       (inst_i),
    .br_cond_i    (br_cond_i),
    .br_val_i     (br_val_i),
    .inst_o       (inst_o),
    .inst_valid_o (inst_valid_o),
    .halted_o     (halted_o)
`ifdef INST_FETCH_ICOUNT_EN
    ,
    .icount_o     (icount_o)
`endif
  );

  // Monitor: one expectation per clock, compared away from the active edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (address_o !== e.a || inst_o !== e.i || inst_valid_o !== e.v || halted_o !== e.h) begin
        failures++;
        $display("FAIL %s: got addr=%0d inst=%h valid=%b halted=%b, want addr=%0d inst=%h valid=%b halted=%b",
                 e.nm, address_o, inst_o, inst_valid_o, halted_o, e.a, e.i, e.v, e.h);
      end else begin
        $display("ok   %s: addr=%0d inst=%h valid=%b halted=%b", e.nm, e.a, e.i, e.v, e.h);
      end
    end
  end

  task automatic step(input logic rst, input logic st, input logic [7:0] sa,
                      input logic stl, input logic cnd, input logic [7:0] bv,
                      input logic [7:0] ea, input logic [7:0] ei,
                      input logic ev, input logic eh, input string nm);
    exp_t e;
    reset        = rst;
    start_i      = st;
    start_addr_i = sa;
    stall_i      = stl;
    br_cond_i    = cnd;
    br_val_i     = bv;
    if (rst || st)
      model_cnt = 16'h0000;
    else if (prev_valid && !stl && model_cnt != 16'hffff)
      model_cnt = model_cnt + 16'd1;
    prev_valid = ev;
    @(posedge clk);
    #1;
    e.a = ea; e.i = ei; e.v = ev; e.h = eh; e.nm = nm;
    sb.push_back(e);
  endtask

  // Ordinary sequential fetch of address n: IR takes rom[n], PC moves to n+1.
  task automatic fetch(input logic [7:0] n);
    step(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, n + 8'd1, rom[n], 1'b1, 1'b0, "fetch");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 256; k++) rom[k] = k[7:0];
    rom[17]  = 8'hF1;   // forward branch
    rom[49]  = 8'hB2;   // backward branch
    rom[99]  = 8'h88;   // halt ending program 1
    rom[110] = 8'h88;   // halt ending program 2
    rom[136] = 8'h00;

    reset = 1'b1; start_i = 1'b0; start_addr_i = 8'd0;
    stall_i = 1'b0; br_cond_i = 1'b0; br_val_i = 8'd0;

    step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 8'd0, 8'h00, 1'b0, 1'b0, "reset");
    step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 8'd0, 8'h00, 1'b0, 1'b0, "reset");
    step(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 8'd0, 8'h00, 1'b0, 1'b0, "idle_hold");

    // Start at 0 and run up to the forward branch.
    step(1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 8'd0, 8'd0, 8'h00, 1'b0, 1'b0, "start0");
    for (int n = 0; n <= 17; n++) fetch(n[7:0]);
    step(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 8'd8, 8'd26, 8'hF1, 1'b0, 1'b0, "br_fwd_taken");
    for (int n = 26; n <= 49; n++) fetch(n[7:0]);
    // Stalled branch must not redirect.
    step(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 8'd38, 8'd50, 8'hB2, 1'b1, 1'b0, "stall_on_branch");
    step(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 8'd38, 8'd12, 8'hB2, 1'b0, 1'b0, "br_bwd_taken");
    for (int n = 12; n <= 49; n++) fetch(n[7:0]);
    step(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd38, 8'd51, 8'd50, 1'b1, 1'b0, "br_bwd_untaken");

    for (int k = 0; k < 3; k++)
      step(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 8'd5, 8'd51, 8'd50, 1'b1, 1'b0, "stall");
    fetch(8'd51);

    // Reset mid-run outranks a simultaneous start and stall.
    step(1'b1, 1'b1, 8'd100, 1'b1, 1'b0, 8'd0, 8'd0, 8'h00, 1'b0, 1'b0, "reset_midrun");
    step(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 8'd0, 8'h00, 1'b0, 1'b0, "idle_after_reset");

    // Program 2 runs to its halt at 110.
    step(1'b0, 1'b1, 8'd100, 1'b0, 1'b0, 8'd0, 8'd100, 8'h00, 1'b0, 1'b0, "start100");
    for (int n = 100; n <= 110; n++) fetch(n[7:0]);
    step(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 8'd111, 8'h88, 1'b0, 1'b1, "halt");
    step(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 8'd7, 8'd111, 8'h88, 1'b0, 1'b1, "halt_ignores");
    step(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 8'd7, 8'd111, 8'h88, 1'b0, 1'b1, "halt_ignores");
    step(1'b0, 1'b1, 8'd152, 1'b0, 1'b0, 8'd0, 8'd152, 8'h88, 1'b0, 1'b0, "start152");
    fetch(8'd152);
    fetch(8'd153);

    // Restart in RUN to 254, then wrap through 255 (8'hff is an ordinary opcode).
    step(1'b0, 1'b1, 8'd254, 1'b0, 1'b0, 8'd0, 8'd254, 8'd153, 1'b0, 1'b0, "restart254");
    fetch(8'd254);
    step(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 8'd0, 8'hFF, 1'b1, 1'b0, "wrap");
    fetch(8'd0);

    // Start outranks stall; then run program 1 to its halt at 99.
    step(1'b0, 1'b1, 8'd0, 1'b1, 1'b1, 8'd3, 8'd0, 8'h00, 1'b0, 1'b0, "start_over_stall");
    for (int n = 0; n <= 40; n++) fetch(n[7:0]);
    step(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 8'd41, 8'd40, 1'b1, 1'b0, "stall_p1");
    step(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 8'd41, 8'd40, 1'b1, 1'b0, "stall_p1");
    for (int n = 41; n <= 99; n++) fetch(n[7:0]);
    step(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 8'd100, 8'h88, 1'b0, 1'b1, "halt_p1");

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end

`ifdef INST_FETCH_ICOUNT_EN
    checks++;
    if (icount_o !== model_cnt) begin
      failures++;
      $display("FAIL icount: got %0d, want %0d", icount_o, model_cnt);
    end else begin
      $display("ok   icount: %0d", model_cnt);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 8'd0, meaning the PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start_i, input, 1, a one-cycle pulse that begins execution at start_addr_i.
REQ-005 SHALL have port start_addr_i, input, 8, the program entry address (0, 100 and 152 for the three resident programs).
REQ-006 SHALL have port stall_i, input, 1, which freezes PC, IR and state.
REQ-007 SHALL have port address_o, output, 8, the instruction-ROM address, equal to the PC register.
REQ-008 SHALL have port inst_i, input, 8, the ROM data, combinational from address_o.
REQ-009 SHALL have port br_cond_i, input, 1, the execute-stage condition flag (seq/slt result).
REQ-010 SHALL have port br_val_i, input, 8, the register value named by IR[2:0], supplied by the execute stage.
REQ-011 SHALL have port inst_o, output, 8, the instruction register (IR) presented to decode/execute.
REQ-012 SHALL have port inst_valid_o, output, 1, high when inst_o is a live instruction.
REQ-013 SHALL have port halted_o, output, 1, high while in the HALT state.

Function
REQ-014 SHALL implement states IDLE, RUN and HALT.
REQ-015 SHALL, in IDLE, hold the PC, keep inst_valid_o at 0, and on start_i load PC <= start_addr_i, clear IR valid and enter RUN.
REQ-016 SHALL, in RUN with stall_i low and no redirect, load IR <= inst_i, IRPC <= PC, PC <= PC+1 and set inst_valid_o to 1.
REQ-017 SHALL decode branches on a valid IR: IR[7:3]=11110 is forward and IR[7:3]=10110 is backward; a branch is taken when br_cond_i=1.
REQ-018 SHALL compute a taken target of IRPC+1+br_val_i (forward) or IRPC+1-br_val_i (backward), modulo 256.
REQ-019 SHALL, on a taken branch, load PC <= target and clear IR valid for one cycle, flushing the instruction fetched that cycle.
REQ-020 SHALL treat an untaken branch as a normal sequential fetch.
REQ-021 SHALL, when a valid IR equals 8'b10001000 (halt), enter HALT, clear IR valid, freeze PC at IRPC+1 and raise halted_o the next cycle.
REQ-022 SHALL, in HALT, ignore stall_i and branch inputs, and on start_i behave as described in REQ-015.
REQ-023 SHALL, while stall_i=1 in RUN, hold PC, IR, IRPC and inst_valid_o; branch and halt evaluation are suppressed that cycle.
REQ-024 SHALL, on start_i in RUN, restart: PC <= start_addr_i and IR valid cleared; start_i takes priority over branch, halt and stall.
REQ-025 SHALL wrap the PC from 255 to 0 without any flag.
REQ-026 SHALL not treat the ROM default value 8'hff as special; it decodes as an ordinary instruction.

Reset
REQ-027 SHALL, on reset, set state to IDLE, PC to RESET_PC (so address_o=RESET_PC), IR to 8'h00, IRPC to 0, inst_valid_o to 0 and halted_o to 0.
REQ-028 SHALL give reset priority over start_i and stall_i, including during RUN and HALT.

Configuration
REQ-029 SHALL, when INST_FETCH_ICOUNT_EN is defined, add output icount_o (16 bits) that resets to 0, increments by 1 per cycle in which inst_valid_o=1 and stall_i=0, saturates at 16'hffff, and clears on start_i.
REQ-030 SHALL, without INST_FETCH_ICOUNT_EN, omit icount_o and its counter entirely.

Verification
REQ-031 Reset, then start_i with start_addr_i=0 -> address_o sequence 0,1,2,...; inst_valid_o goes high one cycle after the start pulse.
REQ-032 Branch forward with IRPC=17, br_val_i=8, br_cond_i=1 -> next address_o=26, one flushed cycle, then IR holds inst(26).
REQ-033 Branch backward with IRPC=49, br_val_i=38, br_cond_i=1 -> address_o=12; repeat with br_cond_i=0 -> address_o continues at 51.
REQ-034 Start at 100 and run to the halt at 110 -> halted_o=1 and address_o frozen at 111; start_i with start_addr_i=152 -> resumes at 152.
REQ-035 stall_i high for 3 cycles mid-run -> PC and inst_o unchanged; reset asserted mid-RUN -> IDLE with address_o=RESET_PC the next cycle.
REQ-036 With INST_FETCH_ICOUNT_EN, run program 1 (addresses 0..99) to halt -> icount_o equals the bench-model count of valid unstalled cycles.
